// File: rtl/sub_serial4.sv
// Nibble-serial subtractor: D = A - B - BI, four bits per clock, registered borrow chain.
// Optional signed-overflow output is enabled by defining SUB_SERIAL_OVF_EN.
module sub_serial4 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bi,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bo
`ifdef SUB_SERIAL_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              c_q, c_d;
    logic [WIDTH-1:0]  d_q, d_d;
    logic              bo_q, bo_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [3:0]        a_nib_s;
    logic [3:0]        b_nib_s;
    logic [4:0]        sum_s;
`ifdef SUB_SERIAL_OVF_EN
    logic              ovf_q, ovf_d;
    logic [3:0]        low_s;
`endif

    // Next-state, datapath step and registered-output decode.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        d_d     = d_q;
        bo_d    = bo_q;
`ifdef SUB_SERIAL_OVF_EN
        ovf_d   = ovf_q;
`endif
        a_nib_s = a_q[{idx_q, 2'b00} +: 4];
        b_nib_s = b_q[{idx_q, 2'b00} +: 4];
        // Subtraction as A + ~B + carry, where the initial carry is ~BI.
        sum_s   = {1'b0, a_nib_s} + {1'b0, ~b_nib_s} + {4'b0000, c_q};
`ifdef SUB_SERIAL_OVF_EN
        low_s   = {1'b0, a_nib_s[2:0]} + {1'b0, ~b_nib_s[2:0]} + {3'b000, c_q};
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    c_d     = ~bi;
                    idx_d   = {IDXW{1'b0}};
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                d_d[{idx_q, 2'b00} +: 4] = sum_s[3:0];
                c_d = sum_s[4];
                if (idx_q == LAST_IDX) begin
                    bo_d    = ~sum_s[4];
`ifdef SUB_SERIAL_OVF_EN
                    ovf_d   = low_s[3] ^ sum_s[4];
`endif
                    idx_d   = {IDXW{1'b0}};
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    c_d     = ~bi;
                    idx_d   = {IDXW{1'b0}};
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_BUSY);
        done_d = (state_d == ST_DONE);
    end

    // State, operand and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= {IDXW{1'b0}};
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            c_q     <= 1'b0;
            d_q     <= {WIDTH{1'b0}};
            bo_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SUB_SERIAL_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            d_q     <= d_d;
            bo_q    <= bo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SUB_SERIAL_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign d    = d_q;
    assign bo   = bo_q;
`ifdef SUB_SERIAL_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_sub_serial4.sv
// Directed and randomised self-checking bench for sub_serial4 (WIDTH=32).
module tb_sub_serial4;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        bi;
    logic        busy;
    logic        done;
    logic [31:0] d;
    logic        bo;
`ifdef SUB_SERIAL_OVF_EN
    logic        ovf;
`endif

    int n_vec;
    int n_err;

    sub_serial4 #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bi    (bi),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .bo    (bo)
`ifdef SUB_SERIAL_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
        end
    endtask

    // Present operands with start for one rising edge, then scramble the inputs.
    task automatic launch(input logic [31:0] av, input logic [31:0] bv, input logic biv);
        a = av;
        b = bv;
        bi = biv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = ~av;
        b = ~bv;
        bi = ~biv;
    endtask

    // Count negedges until done (bounded); also count busy cycles and busy&done overlap.
    task automatic wait_done(output int lat, output int bcnt, output int both);
        bit seen;
        seen = 1'b0;
        lat  = 0;
        bcnt = 0;
        both = 0;
        for (int n = 1; n <= 20 && !seen; n++) begin
            @(negedge clk);
            if (busy && done) both++;
            if (done) begin
                seen = 1'b1;
                lat  = n;
            end else if (busy) begin
                bcnt++;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic biv, input logic [31:0] exp_d, input logic exp_bo);
        int lat, bcnt, both;
        launch(av, bv, biv);
        wait_done(lat, bcnt, both);
        check({tag, "_lat"}, 64'(lat), 64'd9);
        check({tag, "_busy"}, 64'(bcnt), 64'd8);
        check({tag, "_ovl"}, 64'(both), 64'd0);
        check({tag, "_d"}, 64'(d), 64'(exp_d));
        check({tag, "_bo"}, 64'(bo), 64'(exp_bo));
        @(negedge clk);
        check({tag, "_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int lat, bcnt, both, dcnt;
        logic [31:0] ra, rb;
        logic        rbi;
        logic [32:0] model;

        n_vec = 0;
        n_err = 0;
        start = 1'b0;
        a = 32'd0;
        b = 32'd0;
        bi = 1'b0;
        rst_n = 1'b0;
        #23;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_d", 64'(d), 64'd0);
        check("rst_bo", 64'(bo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("t1", 32'd5, 32'd3, 1'b0, 32'h0000_0002, 1'b0);
`ifdef SUB_SERIAL_OVF_EN
        check("t1_ovf", 64'(ovf), 64'd0);
`endif
        run_op("t2a", 32'd3, 32'd5, 1'b0, 32'hFFFF_FFFE, 1'b1);
        run_op("t2b", 32'd0, 32'd0, 1'b1, 32'hFFFF_FFFF, 1'b1);
        run_op("t3", 32'h1000_0000, 32'h0000_0001, 1'b0, 32'h0FFF_FFFF, 1'b0);
        run_op("t3m", 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0);
`ifdef SUB_SERIAL_OVF_EN
        check("t3_ovf", 64'(ovf), 64'd1);
`endif
        check("hold_d", 64'(d), 64'h7FFF_FFFF);

        // Start during BUSY is ignored; start held in DONE chains the next operation.
        launch(32'h0000_0100, 32'h0000_0001, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        launch(32'h0000_0050, 32'h0000_0020, 1'b0);
        wait_done(lat, bcnt, both);
        check("t4_lat", 64'(lat), 64'd6);
        check("t4_d", 64'(d), 64'h0000_00FF);
        check("t4_bo", 64'(bo), 64'd0);
        launch(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_done(lat, bcnt, both);
        check("t4b_lat", 64'(lat), 64'd9);
        check("t4b_d", 64'(d), 64'hFFFF_FFFF);
        check("t4b_bo", 64'(bo), 64'd1);
        @(negedge clk);

        // Reset in the middle of an operation.
        launch(32'h1234_5678, 32'h1111_1111, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_done", 64'(done), 64'd0);
        check("t5_d", 64'(d), 64'd0);
        check("t5_bo", 64'(bo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        for (int n = 0; n < 14; n++) begin
            @(negedge clk);
            if (done || busy) dcnt++;
        end
        check("t5_quiet", 64'(dcnt), 64'd0);

        // Random sweep against a 33-bit reference subtraction.
        for (int i = 0; i < 1000; i++) begin
            ra  = $urandom;
            rb  = $urandom;
            rbi = 1'($urandom_range(1, 0));
            if (i % 50 == 0) rb = ra;
            model = {1'b0, ra} - {1'b0, rb} - {32'd0, rbi};
            launch(ra, rb, rbi);
            wait_done(lat, bcnt, both);
            check("rnd_lat", 64'(lat), 64'd9);
            check("rnd_d", 64'(d), 64'(model[31:0]));
            check("rnd_bo", 64'(bo), 64'(model[32]));
            @(negedge clk);
            check("rnd_pulse", 64'(done), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
